// File: rtl/agc_ctr_pkg.sv
// Shared types and constants for the involuntary-counter priority chain.
// The state enum and the increment-type encoding are used by the top-level FSM.
package agc_ctr_pkg;

   typedef enum logic {
      IDLE,
      GRANT
   } state_e;

   typedef enum logic [1:0] {
      INC_NONE,
      INC_PLUS,
      INC_MINUS,
      INC_DINC
   } inc_e;

   localparam logic [5:0] DEFAULT_BASE_ADDR = 6'o24;

endpackage

// File: rtl/agc_ctr_cell.sv
// One counter channel: plus/minus request latches with net-zero cancellation,
// set-beats-clear on service, and a sticky overrun flag.
module agc_ctr_cell #(
   parameter bit DINC = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic gojam,
   input  logic req_p,
   input  logic req_m,
   input  logic hold,
   input  logic clr_p,
   input  logic clr_m,
   input  logic overrun_clr,
   output logic pend_p,
   output logic pending,
   output logic overrun
);

   logic pend_m;
   logic req_m_eff;
   logic nxt_p;
   logic nxt_m;
   logic ovr_set;

   // NOTE: every signal gets a value before any conditional override, so no latch is inferred.
   always_comb begin
      req_m_eff = req_m & ~DINC;
      nxt_p     = (pend_p & ~clr_p) | req_p;
      nxt_m     = (pend_m & ~clr_m) | req_m_eff;
      ovr_set   = (req_p & pend_p & ~clr_p) | (req_m_eff & pend_m & ~clr_m);
      // A channel under service keeps an opposite pulse so it survives the clear.
      if (!DINC && !hold && nxt_p && nxt_m) begin
         nxt_p = 1'b0;
         nxt_m = 1'b0;
      end
   end

   assign pending = DINC ? pend_p : (pend_p ^ pend_m);

   // NOTE: state registers use non-blocking assignments so all flops update together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_p  <= 1'b0;
         pend_m  <= 1'b0;
         overrun <= 1'b0;
      end else if (gojam) begin
         pend_p  <= 1'b0;
         pend_m  <= 1'b0;
         overrun <= 1'b0;
      end else begin
         pend_p <= nxt_p;
         pend_m <= nxt_m;
         if (ovr_set)
            overrun <= 1'b1;
         else if (overrun_clr)
            overrun <= 1'b0;
      end
   end

endmodule

// File: rtl/agc_counter_priority.sv
// Involuntary-counter request latches plus fixed-priority grant FSM.
// Channel 0 wins; a grant is held until t_done, then the serviced latch is reset.
module agc_counter_priority
   import agc_ctr_pkg::*;
#(
   parameter int                NCHAN     = 16,
   parameter int                ADDRW     = 6,
   parameter logic [ADDRW-1:0]  BASE_ADDR = ADDRW'(DEFAULT_BASE_ADDR),
   parameter logic [NCHAN-1:0]  DINC_MASK = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             gojam,
   input  logic             inhibit,
   input  logic             t_start,
   input  logic             t_done,
   input  logic [NCHAN-1:0] req_p,
   input  logic [NCHAN-1:0] req_m,
   input  logic             overrun_clr,
   output logic             ctr_req,
   output logic [ADDRW-1:0] ctr_addr,
   output logic             ctr_plus,
   output logic             ctr_minus,
   output logic             ctr_dinc,
   output logic [NCHAN-1:0] chan_clr,
   output logic [NCHAN-1:0] overrun
);

   localparam int IDXW = (NCHAN > 1) ? $clog2(NCHAN) : 1;

   state_e            state;
   logic [IDXW-1:0]   gnt_idx;
   logic [NCHAN-1:0]  pend_p;
   logic [NCHAN-1:0]  pending;
   logic              sel_found;
   logic [IDXW-1:0]   sel_idx;
   inc_e              sel_type;
   logic              done_ev;

   assign done_ev = (state == GRANT) && t_done;

   for (genvar g = 0; g < NCHAN; g++) begin : g_cell
      logic is_gnt;
      assign is_gnt = (gnt_idx == IDXW'(g));

      agc_ctr_cell #(
         .DINC (DINC_MASK[g])
      ) u_cell (
         .clk         (clk),
         .rst         (rst),
         .gojam       (gojam),
         .req_p       (req_p[g]),
         .req_m       (req_m[g]),
         .hold        ((state == GRANT) && is_gnt),
         .clr_p       (done_ev && is_gnt && (ctr_plus || ctr_dinc)),
         .clr_m       (done_ev && is_gnt && ctr_minus),
         .overrun_clr (overrun_clr),
         .pend_p      (pend_p[g]),
         .pending     (pending[g]),
         .overrun     (overrun[g])
      );
   end

   // Descending scan so the lowest pending index is the one left standing.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      for (int i = NCHAN - 1; i >= 0; i--) begin
         if (pending[i]) begin
            sel_found = 1'b1;
            sel_idx   = IDXW'(i);
         end
      end
      if (DINC_MASK[sel_idx])
         sel_type = INC_DINC;
      else if (pend_p[sel_idx])
         sel_type = INC_PLUS;
      else
         sel_type = INC_MINUS;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         gnt_idx   <= '0;
         ctr_req   <= 1'b0;
         ctr_addr  <= BASE_ADDR;
         ctr_plus  <= 1'b0;
         ctr_minus <= 1'b0;
         ctr_dinc  <= 1'b0;
         chan_clr  <= '0;
      end else if (gojam) begin
         state     <= IDLE;
         gnt_idx   <= '0;
         ctr_req   <= 1'b0;
         ctr_addr  <= BASE_ADDR;
         ctr_plus  <= 1'b0;
         ctr_minus <= 1'b0;
         ctr_dinc  <= 1'b0;
         chan_clr  <= '0;
      end else begin
         chan_clr <= '0;
         case (state)
            IDLE: begin
               if (t_start && !inhibit && sel_found) begin
                  state     <= GRANT;
                  gnt_idx   <= sel_idx;
                  ctr_req   <= 1'b1;
                  ctr_addr  <= BASE_ADDR + ADDRW'(sel_idx);
                  ctr_plus  <= (sel_type == INC_PLUS);
                  ctr_minus <= (sel_type == INC_MINUS);
                  ctr_dinc  <= (sel_type == INC_DINC);
               end
            end
            GRANT: begin
               if (t_done) begin
                  state     <= IDLE;
                  chan_clr  <= NCHAN'(1) << gnt_idx;
                  ctr_req   <= 1'b0;
                  ctr_addr  <= BASE_ADDR;
                  ctr_plus  <= 1'b0;
                  ctr_minus <= 1'b0;
                  ctr_dinc  <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_agc_counter_priority.sv
// Directed bench: stimulus queues expected grants/clears, a negedge monitor
// pops and compares them whenever the DUT raises ctr_req or pulses chan_clr.
module tb_agc_counter_priority;

   typedef struct {
      logic [5:0] addr;
      logic       plus;
      logic       minus;
      logic       dinc;
   } gnt_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        gojam;
   logic        inhibit;
   logic        t_start;
   logic        t_done;
   logic [15:0] req_p;
   logic [15:0] req_m;
   logic        overrun_clr;
   logic        ctr_req;
   logic [5:0]  ctr_addr;
   logic        ctr_plus;
   logic        ctr_minus;
   logic        ctr_dinc;
   logic [15:0] chan_clr;
   logic [15:0] overrun;

   int n_checks = 0;
   int n_fail   = 0;

   gnt_t        exp_gnt[$];
   logic [15:0] exp_clr[$];

   always #5 clk = ~clk;

   agc_counter_priority #(
      .NCHAN     (16),
      .ADDRW     (6),
      .BASE_ADDR (6'o24),
      .DINC_MASK (16'h0001)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .gojam       (gojam),
      .inhibit     (inhibit),
      .t_start     (t_start),
      .t_done      (t_done),
      .req_p       (req_p),
      .req_m       (req_m),
      .overrun_clr (overrun_clr),
      .ctr_req     (ctr_req),
      .ctr_addr    (ctr_addr),
      .ctr_plus    (ctr_plus),
      .ctr_minus   (ctr_minus),
      .ctr_dinc    (ctr_dinc),
      .chan_clr    (chan_clr),
      .overrun     (overrun)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: compares whenever the DUT presents a new grant or a clear pulse.
   logic prev_req = 1'b0;
   always @(negedge clk) begin
      gnt_t        e;
      logic [15:0] c;
      if (rst) begin
         prev_req = 1'b0;
      end else begin
         if (ctr_req && !prev_req) begin
            if (exp_gnt.size() == 0) begin
               check("grant_unexpected", {26'd0, ctr_addr}, 32'hffff_ffff);
            end else begin
               e = exp_gnt.pop_front();
               check("grant_addr",  {26'd0, ctr_addr}, {26'd0, e.addr});
               check("grant_plus",  {31'd0, ctr_plus},  {31'd0, e.plus});
               check("grant_minus", {31'd0, ctr_minus}, {31'd0, e.minus});
               check("grant_dinc",  {31'd0, ctr_dinc},  {31'd0, e.dinc});
            end
         end
         if (chan_clr != 16'h0) begin
            if (exp_clr.size() == 0) begin
               check("clr_unexpected", {16'd0, chan_clr}, 32'd0);
            end else begin
               c = exp_clr.pop_front();
               check("chan_clr", {16'd0, chan_clr}, {16'd0, c});
            end
         end
         prev_req = ctr_req;
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [15:0] p, input logic [15:0] m, input bit ts, input bit td);
      req_p   = p;
      req_m   = m;
      t_start = ts;
      t_done  = td;
      @(posedge clk);
      #1;
      req_p   = '0;
      req_m   = '0;
      t_start = 1'b0;
      t_done  = 1'b0;
   endtask

   function automatic gnt_t mk(input logic [5:0] a, input logic p, input logic m, input logic d);
      gnt_t g;
      g.addr  = a;
      g.plus  = p;
      g.minus = m;
      g.dinc  = d;
      return g;
   endfunction

   initial begin
      rst = 1'b1; gojam = 1'b0; inhibit = 1'b0; t_start = 1'b0; t_done = 1'b0;
      req_p = '0; req_m = '0; overrun_clr = 1'b0;
      idle(2);
      check("rst_req",     {31'd0, ctr_req}, 32'd0);
      check("rst_addr",    {26'd0, ctr_addr}, 32'o24);
      check("rst_chan_clr", {16'd0, chan_clr}, 32'd0);
      check("rst_overrun", {16'd0, overrun}, 32'd0);
      rst = 1'b0;
      idle(1);

      // Single plus request on channel 3.
      drive(16'h0008, 16'h0000, 0, 0);
      exp_gnt.push_back(mk(6'o27, 1, 0, 0));
      drive(16'h0000, 16'h0000, 1, 0);
      idle(2);
      exp_clr.push_back(16'h0008);
      drive(16'h0000, 16'h0000, 0, 1);
      idle(1);
      check("t1_clr_one_cycle", {16'd0, chan_clr}, 32'd0);
      check("t1_req_low",       {31'd0, ctr_req}, 32'd0);

      // Priority: channel 2 minus before channel 5 plus.
      drive(16'h0020, 16'h0004, 0, 0);
      exp_gnt.push_back(mk(6'o26, 0, 1, 0));
      drive(16'h0000, 16'h0000, 1, 0);
      idle(1);
      exp_clr.push_back(16'h0004);
      drive(16'h0000, 16'h0000, 0, 1);
      exp_gnt.push_back(mk(6'o31, 1, 0, 0));
      drive(16'h0000, 16'h0000, 1, 0);
      idle(1);
      exp_clr.push_back(16'h0020);
      drive(16'h0000, 16'h0000, 0, 1);
      idle(1);

      // Plus then minus on channel 4 cancel.
      drive(16'h0010, 16'h0000, 0, 0);
      drive(16'h0000, 16'h0010, 0, 0);
      drive(16'h0000, 16'h0000, 1, 0);
      idle(1);
      check("t3_cancel_no_grant", {31'd0, ctr_req}, 32'd0);

      // DINC channel 0 and overrun.
      drive(16'h0001, 16'h0000, 0, 0);
      drive(16'h0001, 16'h0000, 0, 0);
      check("t4_overrun_set", {16'd0, overrun}, 32'h0001);
      exp_gnt.push_back(mk(6'o24, 0, 0, 1));
      drive(16'h0000, 16'h0000, 1, 0);
      idle(1);
      exp_clr.push_back(16'h0001);
      drive(16'h0000, 16'h0000, 0, 1);
      idle(1);
      check("t4_overrun_sticky", {16'd0, overrun}, 32'h0001);
      overrun_clr = 1'b1;
      idle(1);
      overrun_clr = 1'b0;
      check("t4_overrun_cleared", {16'd0, overrun}, 32'd0);

      // Inhibit blocks a grant; released inhibit lets it through.
      inhibit = 1'b1;
      drive(16'h0002, 16'h0000, 0, 0);
      drive(16'h0000, 16'h0000, 1, 0);
      idle(1);
      check("t5_inhibit_no_grant", {31'd0, ctr_req}, 32'd0);
      inhibit = 1'b0;
      exp_gnt.push_back(mk(6'o25, 1, 0, 0));
      drive(16'h0000, 16'h0000, 1, 0);
      idle(1);
      exp_clr.push_back(16'h0002);
      drive(16'h0000, 16'h0000, 0, 1);
      idle(1);

      // No pre-emption, opposite pulse kept across clear, coincident strobes.
      exp_gnt.push_back(mk(6'o32, 1, 0, 0));
      drive(16'h0040, 16'h0000, 0, 0);
      drive(16'h0000, 16'h0000, 1, 0);
      drive(16'h0002, 16'h0040, 1, 0);
      check("t6_held_addr", {26'd0, ctr_addr}, 32'o32);
      inhibit = 1'b1;
      idle(1);
      exp_clr.push_back(16'h0040);
      drive(16'h0000, 16'h0000, 1, 1);
      inhibit = 1'b0;
      idle(1);
      check("t6_coincident_ignored", {31'd0, ctr_req}, 32'd0);
      exp_gnt.push_back(mk(6'o25, 1, 0, 0));
      drive(16'h0000, 16'h0000, 1, 0);
      idle(1);
      exp_clr.push_back(16'h0002);
      drive(16'h0000, 16'h0000, 0, 1);
      exp_gnt.push_back(mk(6'o32, 0, 1, 0));
      drive(16'h0000, 16'h0000, 1, 0);
      idle(1);
      exp_clr.push_back(16'h0040);
      drive(16'h0000, 16'h0040, 0, 1);
      check("t6_set_beats_clear_no_ovr", {16'd0, overrun}, 32'd0);
      exp_gnt.push_back(mk(6'o32, 0, 1, 0));
      drive(16'h0000, 16'h0000, 1, 0);
      idle(1);
      exp_clr.push_back(16'h0040);
      drive(16'h0000, 16'h0000, 0, 1);
      idle(1);

      // Asynchronous reset in the middle of a grant.
      drive(16'h0080, 16'h0000, 0, 0);
      req_p = '0;
      t_start = 1'b1;
      @(posedge clk);
      #1;
      t_start = 1'b0;
      check("t7_grant_before_rst", {26'd0, ctr_addr}, 32'o33);
      #2;
      rst = 1'b1;
      #1;
      check("t7_rst_req",  {31'd0, ctr_req}, 32'd0);
      check("t7_rst_addr", {26'd0, ctr_addr}, 32'o24);
      check("t7_rst_plus", {31'd0, ctr_plus}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      drive(16'h0000, 16'h0000, 1, 0);
      idle(1);
      check("t7_no_stale_grant", {31'd0, ctr_req}, 32'd0);

      // gojam clears a pending request synchronously.
      drive(16'h0100, 16'h0000, 0, 0);
      gojam = 1'b1;
      idle(1);
      gojam = 1'b0;
      drive(16'h0000, 16'h0000, 1, 0);
      idle(1);
      check("t8_gojam_no_grant", {31'd0, ctr_req}, 32'd0);

      for (int i = 0; i < 20; i++) begin
         if (exp_gnt.size() == 0 && exp_clr.size() == 0) break;
         idle(1);
      end
      check("drain_grants", exp_gnt.size(), 32'd0);
      check("drain_clears", exp_clr.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/agc_counter_priority.md
Name: agc_counter_priority

Overview:
- Parametrised involuntary-counter request latch and priority chain: successor to the fixed 11-channel counter-cell logic.
- Holds per-channel plus/minus/diminish requests and selects the highest-priority pending channel at each memory-cycle boundary.
- Drives counter address, increment type and counter-request-pending to the sequence generator, then issues a per-channel request reset when the counter cycle completes.
- Adds over the fixed version: configurable channel count and base address, per-channel DINC mode, plus/minus cancellation, sticky overrun flags.

Parameters:
- NCHAN, 16, number of counter channels; index 0 is highest priority.
- ADDRW, 6, width of counter address output.
- BASE_ADDR, 6'o24, erasable address of channel 0; channel i maps to BASE_ADDR+i.
- DINC_MASK, 16'h0000, bit i=1 makes channel i a diminishing (DINC) counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- gojam  in  1  synchronous clear, same effect as rst.
- inhibit  in  1  blocks new grants (MNHNC/GNHNC equivalent); does not clear latches.
- t_start  in  1  one-cycle strobe: priority sample point.
- t_done  in  1  one-cycle strobe: counter cycle finished.
- req_p  in  NCHAN  one-cycle plus-request pulses (DINC request for DINC channels).
- req_m  in  NCHAN  one-cycle minus-request pulses; ignored on DINC channels.
- overrun_clr  in  1  clears all overrun flags.
- ctr_req  out  1  counter request pending/granted (CTROR).
- ctr_addr  out  ADDRW  address of granted channel.
- ctr_plus  out  1  granted operation is PINC.
- ctr_minus  out  1  granted operation is MINC.
- ctr_dinc  out  1  granted operation is DINC.
- chan_clr  out  NCHAN  one-cycle request-reset pulse (the R outputs).
- overrun  out  NCHAN  sticky: request arrived while the same polarity was already pending.

Behaviour:
- Reset (rst async, gojam sync): all latches 0, state IDLE; ctr_req, ctr_plus, ctr_minus, ctr_dinc = 0; ctr_addr = BASE_ADDR; chan_clr = 0; overrun = 0.
- Latches: pend_p[i] is set by req_p[i] and pend_m[i] by req_m[i]. On non-DINC channels, if both are set after an update, both are cleared (net zero) and no grant occurs.
- Overrun: a req pulse arriving when the same-polarity latch is already set sets overrun[i]. overrun_clr clears all flags. If overrun_clr coincides with a new overrun, set wins.
- States: IDLE and GRANT.
  - IDLE: on t_start with inhibit=0 and any channel pending, select lowest index i. Registered in the next cycle:
    - ctr_req = 1.
    - ctr_addr = BASE_ADDR+i (truncated to ADDRW).
    - For DINC channels: ctr_dinc = 1.
    - For other channels: ctr_plus = pend_p[i], ctr_minus = pend_m[i].
    - Go to GRANT. Latency is 1 clock.
  - IDLE with t_start and no pending channel, or inhibit=1: stay IDLE, outputs unchanged.
  - GRANT: outputs held stable; t_start ignored; new requests still latch.
  - GRANT on t_done: next cycle chan_clr[i] = 1 for one clock, the serviced latch is cleared, ctr_* = 0, return to IDLE.
  - t_start coincident with t_done in GRANT: the t_start is ignored.
- Set beats clear: a req pulse on channel i in the same cycle as its clear leaves the latch set with that pulse's polarity. No overrun is flagged in this case.
- Cancellation during GRANT: an opposite-polarity pulse on the granted channel is latched normally. At clear, only the granted polarity is cleared, and the new request remains pending.
- Selection is made once at t_start. A higher-priority request arriving during GRANT does not pre-empt; it is served at the next t_start.
- inhibit asserted during GRANT does not abort the grant.

Decomposition:
- Shared package agc_ctr_pkg: state enum (IDLE, GRANT), increment-type encoding, default BASE_ADDR constant.
- One sub-module agc_ctr_cell (per-channel plus/minus latch with cancel, set-beats-clear and overrun), instantiated NCHAN times via generate.
- Priority encoder and FSM live in the top module.

Test Plan:
- Reset release, then req_p[3] pulse, t_start -> next cycle ctr_req=1, ctr_addr=6'o27, ctr_plus=1. t_done -> next cycle chan_clr=16'h0008 for one clock, ctr_req=0.
- req_p[5] and req_m[2] together, t_start -> channel 2 granted (ctr_minus=1, addr 6'o26). After t_done, next t_start grants channel 5.
- req_p[4] then req_m[4] before t_start -> both cleared, t_start produces no grant, ctr_req stays 0.
- DINC_MASK=16'h0001, req_p[0] -> ctr_dinc=1, ctr_plus=0. A second req_p[0] before service -> overrun[0]=1 until overrun_clr.
- inhibit=1 with req_p[1] and t_start -> no grant. inhibit=0, next t_start -> grant channel 1.
- rst asserted mid-GRANT (asynchronously, between edges) -> all outputs 0 immediately, ctr_addr=6'o24. After release, no stale grant occurs.
